// File: rtl/rob_retire_ctrl.sv
// rtl/rob_retire_ctrl.sv - in-order reorder buffer with out-of-order writeback and multi-lane retire
module rob_retire_ctrl #(
  parameter int ROB_SIZE       = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int NUM_WB         = 2,
  parameter int DATA_LEN       = 32,
  parameter int SRC_LEN        = 5,
  parameter int ROB_ID_LEN     = $clog2(ROB_SIZE)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [DISPATCH_WIDTH-1:0]          disp_v,
  input  logic [DISPATCH_WIDTH-1:0]          disp_rfWrite,
  input  logic [DISPATCH_WIDTH*SRC_LEN-1:0]  disp_rd,
  output logic                               disp_rdy,
  output logic [DISPATCH_WIDTH*ROB_ID_LEN-1:0] disp_rob_id,
  input  logic [NUM_WB-1:0]                  wb_v,
  input  logic [NUM_WB*ROB_ID_LEN-1:0]       wb_rob_id,
  input  logic [NUM_WB*DATA_LEN-1:0]         wb_data,
  output logic [RETIRE_WIDTH-1:0]            ret_v,
  output logic [RETIRE_WIDTH-1:0]            ret_rfWrite,
  output logic [RETIRE_WIDTH*SRC_LEN-1:0]    ret_rd,
  output logic [RETIRE_WIDTH*DATA_LEN-1:0]   ret_data,
  output logic [ROB_ID_LEN:0]                count
);

  localparam int PW = ROB_ID_LEN + 1;

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         count_w;
  logic [PW-1:0]         free_w;
  logic [PW-1:0]         disp_cnt;
  logic [PW-1:0]         ret_cnt;
  logic [ROB_SIZE-1:0]   ent_valid;
  logic [ROB_SIZE-1:0]   ent_done;
  logic [ROB_SIZE-1:0]   ent_rfw;
  logic [SRC_LEN-1:0]    ent_rd   [ROB_SIZE];
  logic [DATA_LEN-1:0]   ent_data [ROB_SIZE];
  logic [RETIRE_WIDTH-1:0] elig;
  logic                    chain;
  logic [RETIRE_WIDTH-1:0][ROB_ID_LEN-1:0]   ret_idx;
  logic [DISPATCH_WIDTH-1:0][ROB_ID_LEN-1:0] disp_idx;

  // Wrap bit in the MSB makes tail - head the exact occupancy, full included.
  assign count_w     = tail - head;
  assign free_w      = PW'(ROB_SIZE) - count_w;
  assign disp_rdy    = free_w >= PW'(DISPATCH_WIDTH);
  assign count       = count_w;
  assign disp_rob_id = disp_idx;

  always_comb begin
    disp_idx = '0;
    disp_cnt = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      disp_idx[k] = tail[ROB_ID_LEN-1:0] + ROB_ID_LEN'(k);
      disp_cnt    = disp_cnt + PW'(disp_v[k]);
    end
  end

  // A lane retires only if every older lane in this group also retires.
  always_comb begin
    ret_idx = '0;
    elig    = '0;
    ret_cnt = '0;
    chain   = 1'b1;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      ret_idx[i] = head[ROB_ID_LEN-1:0] + ROB_ID_LEN'(i);
      chain      = chain & ent_valid[ret_idx[i]] & ent_done[ret_idx[i]];
      elig[i]    = chain;
      ret_cnt    = ret_cnt + PW'(chain);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
      ent_rfw   <= '0;
      for (int j = 0; j < ROB_SIZE; j++) begin
        ent_rd[j]   <= '0;
        ent_data[j] <= '0;
      end
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      ent_done  <= '0;
    end else begin
      // Later ports override earlier ones on the same entry.
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_v[p] && ent_valid[wb_rob_id[p*ROB_ID_LEN +: ROB_ID_LEN]]) begin
          ent_done[wb_rob_id[p*ROB_ID_LEN +: ROB_ID_LEN]] <= 1'b1;
          ent_data[wb_rob_id[p*ROB_ID_LEN +: ROB_ID_LEN]] <= wb_data[p*DATA_LEN +: DATA_LEN];
        end
      end
      if (disp_rdy) begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
          if (disp_v[k]) begin
            ent_valid[disp_idx[k]] <= 1'b1;
            ent_done[disp_idx[k]]  <= 1'b0;
            ent_rfw[disp_idx[k]]   <= disp_rfWrite[k];
            ent_rd[disp_idx[k]]    <= disp_rd[k*SRC_LEN +: SRC_LEN];
          end
        end
        tail <= tail + disp_cnt;
      end
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        if (elig[i]) begin
          ent_valid[ret_idx[i]] <= 1'b0;
          ent_done[ret_idx[i]]  <= 1'b0;
        end
      end
      head <= head + ret_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_v       <= '0;
      ret_rfWrite <= '0;
      ret_rd      <= '0;
      ret_data    <= '0;
    end else if (flush) begin
      ret_v       <= '0;
      ret_rfWrite <= '0;
      ret_rd      <= '0;
      ret_data    <= '0;
    end else begin
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
        ret_v[i]                          <= elig[i];
        ret_rfWrite[i]                    <= elig[i] & ent_rfw[ret_idx[i]];
        ret_rd[i*SRC_LEN +: SRC_LEN]      <= elig[i] ? ent_rd[ret_idx[i]] : '0;
        ret_data[i*DATA_LEN +: DATA_LEN]  <= elig[i] ? ent_data[ret_idx[i]] : '0;
      end
    end
  end

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// tb/tb_rob_retire_ctrl.sv - directed vector table, corner sequences and queue-model random run
module tb_rob_retire_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [1:0]  disp_v;
  logic [1:0]  disp_rfWrite;
  logic [9:0]  disp_rd;
  logic        disp_rdy;
  logic [7:0]  disp_rob_id;
  logic [1:0]  wb_v;
  logic [7:0]  wb_rob_id;
  logic [63:0] wb_data;
  logic [1:0]  ret_v;
  logic [1:0]  ret_rfWrite;
  logic [9:0]  ret_rd;
  logic [63:0] ret_data;
  logic [4:0]  count;

  always #5 clk = ~clk;

  rob_retire_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .disp_v(disp_v), .disp_rfWrite(disp_rfWrite), .disp_rd(disp_rd),
    .disp_rdy(disp_rdy), .disp_rob_id(disp_rob_id),
    .wb_v(wb_v), .wb_rob_id(wb_rob_id), .wb_data(wb_data),
    .ret_v(ret_v), .ret_rfWrite(ret_rfWrite), .ret_rd(ret_rd), .ret_data(ret_data),
    .count(count)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; disp_v = '0; disp_rfWrite = '0; disp_rd = '0;
    wb_v = '0; wb_rob_id = '0; wb_data = '0;
  endtask

  typedef struct {
    int fl, dv, rfw, rd0, rd1, wv, wid0, wid1, wd0, wd1;
    int e_id, e_cnt, e_rdy, e_rv, e_rfw, e_rd0, e_rd1, e_d0, e_d1;
  } vec_t;

  // Reference model: FIFO of in-flight instructions in dispatch order.
  typedef struct {
    int        id;
    bit        rfw;
    bit [4:0]  rd;
    bit        done;
    bit [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_tail;
  logic [1:0]  m_ret_v, m_ret_rfw;
  logic [9:0]  m_ret_rd;
  logic [63:0] m_ret_data;

  task automatic model_edge();
    int   n;
    bit   rdy;
    ent_t e;
    m_ret_v = '0; m_ret_rfw = '0; m_ret_rd = '0; m_ret_data = '0;
    if (flush) begin
      q.delete();
      m_tail = 0;
      return;
    end
    n = 0;
    for (int i = 0; i < 2; i++)
      if (n == i && i < q.size() && q[i].done) n++;
    for (int i = 0; i < n; i++) begin
      m_ret_v[i]              = 1'b1;
      m_ret_rfw[i]            = q[i].rfw;
      m_ret_rd[i*5 +: 5]      = q[i].rd;
      m_ret_data[i*32 +: 32]  = q[i].data;
    end
    rdy = (16 - q.size()) >= 2;
    for (int i = 0; i < n; i++) void'(q.pop_front());
    for (int p = 0; p < 2; p++)
      if (wb_v[p])
        foreach (q[j])
          if (q[j].id == int'(wb_rob_id[p*4 +: 4])) begin
            q[j].done = 1'b1;
            q[j].data = wb_data[p*32 +: 32];
          end
    if (rdy)
      for (int k = 0; k < 2; k++)
        if (disp_v[k]) begin
          e.id = m_tail; e.rfw = disp_rfWrite[k]; e.rd = disp_rd[k*5 +: 5];
          e.done = 1'b0; e.data = '0;
          q.push_back(e);
          m_tail = (m_tail + 1) % 16;
        end
  endtask

  task automatic rand_cycle();
    int r, id;
    flush = ($urandom_range(0, 39) == 0);
    r = $urandom_range(0, 2);
    disp_v = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
    disp_rfWrite = 2'($urandom);
    disp_rd = 10'($urandom);
    for (int p = 0; p < 2; p++) begin
      wb_v[p] = 1'($urandom_range(0, 1));
      if (q.size() > 0 && $urandom_range(0, 3) != 0) id = q[$urandom_range(0, q.size() - 1)].id;
      else id = $urandom_range(0, 15);
      wb_rob_id[p*4 +: 4] = 4'(id);
      wb_data[p*32 +: 32] = $urandom;
    end
    #1;
    chk("rnd_count", 64'(count), 64'(q.size()));
    chk("rnd_rdy", 64'(disp_rdy), 64'((16 - q.size()) >= 2));
    chk("rnd_ids", 64'(disp_rob_id), 64'({4'((m_tail + 1) % 16), 4'(m_tail)}));
    model_edge();
    tick();
    chk("rnd_ret_v", 64'(ret_v), 64'(m_ret_v));
    for (int i = 0; i < 2; i++)
      if (m_ret_v[i]) begin
        chk("rnd_ret_rfw", 64'(ret_rfWrite[i]), 64'(m_ret_rfw[i]));
        chk("rnd_ret_rd", 64'(ret_rd[i*5 +: 5]), 64'(m_ret_rd[i*5 +: 5]));
        chk("rnd_ret_data", 64'(ret_data[i*32 +: 32]), 64'(m_ret_data[i*32 +: 32]));
      end
  endtask

  vec_t vec [14];

  initial begin
    vec[0]  = '{0, 3, 3, 3, 4, 0, 0, 0, 0, 0,          0, 2, 1, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{0, 0, 0, 0, 0, 1, 1, 0, 'hB, 0,        2, 2, 1, 0, 0, 0, 0, 0, 0};
    vec[2]  = '{0, 0, 0, 0, 0, 1, 0, 0, 'hA, 0,        2, 2, 1, 0, 0, 0, 0, 0, 0};
    vec[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          2, 0, 1, 3, 3, 3, 4, 'hA, 'hB};
    vec[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          2, 0, 1, 0, 0, 0, 0, 0, 0};
    vec[5]  = '{0, 0, 0, 0, 0, 2, 0, 7, 0, 'h55,       2, 0, 1, 0, 0, 0, 0, 0, 0};
    vec[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          2, 0, 1, 0, 0, 0, 0, 0, 0};
    vec[7]  = '{0, 3, 1, 5, 6, 0, 0, 0, 0, 0,          2, 2, 1, 0, 0, 0, 0, 0, 0};
    vec[8]  = '{0, 0, 0, 0, 0, 3, 2, 2, 'h111, 'h222,  4, 2, 1, 0, 0, 0, 0, 0, 0};
    vec[9]  = '{0, 0, 0, 0, 0, 1, 3, 0, 'h333, 0,      4, 1, 1, 1, 1, 5, 0, 'h222, 0};
    vec[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          4, 0, 1, 1, 0, 6, 0, 'h333, 0};
    vec[11] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0,          4, 1, 1, 0, 0, 0, 0, 0, 0};
    vec[12] = '{0, 0, 0, 0, 0, 1, 4, 0, 'h44, 0,       5, 1, 1, 0, 0, 0, 0, 0, 0};
    vec[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,          5, 0, 1, 1, 1, 0, 0, 'h44, 0};

    rst_n = 1'b0;
    idle_inputs();
    #3;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_rdy", 64'(disp_rdy), 64'(1));
    chk("rst_ret_v", 64'(ret_v), 64'(0));
    chk("rst_ret_data", 64'(ret_data), 64'(0));
    chk("rst_ids", 64'(disp_rob_id), 64'(8'h10));
    #10 rst_n = 1'b1;
    tick();

    foreach (vec[n]) begin
      flush        = 1'(vec[n].fl);
      disp_v       = 2'(vec[n].dv);
      disp_rfWrite = 2'(vec[n].rfw);
      disp_rd      = {5'(vec[n].rd1), 5'(vec[n].rd0)};
      wb_v         = 2'(vec[n].wv);
      wb_rob_id    = {4'(vec[n].wid1), 4'(vec[n].wid0)};
      wb_data      = {32'(vec[n].wd1), 32'(vec[n].wd0)};
      #1;
      chk("vec_ids", 64'(disp_rob_id), 64'({4'((vec[n].e_id + 1) % 16), 4'(vec[n].e_id)}));
      tick();
      chk("vec_count", 64'(count), 64'(vec[n].e_cnt));
      chk("vec_rdy", 64'(disp_rdy), 64'(vec[n].e_rdy));
      chk("vec_ret_v", 64'(ret_v), 64'(vec[n].e_rv));
      chk("vec_ret_rfw", 64'(ret_rfWrite), 64'(vec[n].e_rfw));
      chk("vec_ret_rd", 64'(ret_rd), 64'({5'(vec[n].e_rd1), 5'(vec[n].e_rd0)}));
      chk("vec_ret_data", 64'(ret_data), {32'(vec[n].e_d1), 32'(vec[n].e_d0)});
    end

    // Fill from head = tail = 5 until one slot remains.
    idle_inputs();
    for (int c = 0; c < 7; c++) begin
      disp_v = 2'b11; disp_rfWrite = 2'b11; disp_rd = 10'($urandom);
      #1;
      chk("fill_rdy", 64'(disp_rdy), 64'(1));
      tick();
    end
    chk("fill_count14", 64'(count), 64'(14));
    disp_v = 2'b01;
    tick();
    chk("fill_count15", 64'(count), 64'(15));
    chk("fill_rdy15", 64'(disp_rdy), 64'(0));
    disp_v = 2'b11;
    tick();
    chk("fill_ignored_count", 64'(count), 64'(15));
    chk("fill_ignored_tail", 64'(disp_rob_id[3:0]), 64'(4));
    chk("fill_ret_v", 64'(ret_v), 64'(0));

    // Flush wins over same-cycle dispatch and writeback.
    flush = 1'b1; disp_v = 2'b11; wb_v = 2'b11; wb_rob_id = 8'h65; wb_data = {32'h1, 32'h2};
    tick();
    idle_inputs();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_ret_v", 64'(ret_v), 64'(0));
    chk("flush_rdy", 64'(disp_rdy), 64'(1));
    chk("flush_ids", 64'(disp_rob_id), 64'(8'h10));
    tick();
    chk("flush_after_ret_v", 64'(ret_v), 64'(0));

    q.delete();
    m_tail = 0;
    for (int c = 0; c < 120; c++) rand_cycle();

    // Asynchronous reset while retire outputs are valid.
    idle_inputs();
    flush = 1'b1;
    tick();
    flush = 1'b0; disp_v = 2'b11; disp_rfWrite = 2'b11; disp_rd = {5'd10, 5'd9};
    tick();
    disp_v = '0; wb_v = 2'b11; wb_rob_id = 8'h10; wb_data = {32'hBEEF, 32'hCAFE};
    tick();
    idle_inputs();
    tick();
    chk("pre_rst_ret_v", 64'(ret_v), 64'(3));
    chk("pre_rst_ret_rd", 64'(ret_rd), 64'({5'd10, 5'd9}));
    rst_n = 1'b0;
    #1;
    chk("async_rst_ret_v", 64'(ret_v), 64'(0));
    chk("async_rst_count", 64'(count), 64'(0));
    chk("async_rst_rdy", 64'(disp_rdy), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
